// File: rtl/utf8_stream_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : utf8_stream_decoder
//  Description : UTF-8 byte stream to Unicode scalar decoder with valid/ready
//                handshakes on both sides. Rejects overlong forms, surrogates,
//                values above U+10FFFF and truncated sequences; each error is
//                either replaced by REPLACEMENT or dropped, and is counted in a
//                saturating error counter.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                in_byte/in_valid/in_ready      - byte input handshake
//                out_code/out_len/out_error     - decoded result fields
//                out_valid/out_ready            - result output handshake
//                err_count                      - saturating error count
//  Revision    : 1.0 - initial release
// ============================================================================
module utf8_stream_decoder #(
    parameter int          MAX_BYTES        = 4,
    parameter bit          EMIT_REPLACEMENT = 1'b1,
    parameter logic [20:0] REPLACEMENT      = 21'h00FFFD,
    parameter int          ERR_CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [20:0]              out_code,
    output logic [2:0]               out_len,
    output logic                     out_error,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NEED3 = 2'd1,
        S_NEED2 = 2'd2,
        S_NEED1 = 2'd3
    } state_t;

    // Result of interpreting one byte as a sequence lead.
    typedef struct packed {
        logic        emit;
        logic        err;
        state_t      nstate;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [14:0] acc;
        logic [2:0]  len;
    } lead_t;

    function automatic lead_t lead_decode(input logic [7:0] b);
        lead_t r;
        r.emit   = 1'b0;
        r.err    = 1'b0;
        r.nstate = S_IDLE;
        r.lo     = 8'h80;
        r.hi     = 8'hBF;
        r.acc    = 15'd0;
        r.len    = 3'd0;
        if (b < 8'h80) begin
            r.emit = 1'b1;
            r.acc  = {7'd0, b};
            r.len  = 3'd1;
        end else if (b >= 8'hC2 && b <= 8'hDF) begin
            r.nstate = S_NEED1;
            r.acc    = {10'd0, b[4:0]};
            r.len    = 3'd2;
        end else if (b >= 8'hE0 && b <= 8'hEF && MAX_BYTES >= 3) begin
            r.nstate = S_NEED2;
            r.acc    = {11'd0, b[3:0]};
            r.len    = 3'd3;
            // E0 would be overlong below A0; ED would reach the surrogates above 9F
            if (b == 8'hE0) r.lo = 8'hA0;
            if (b == 8'hED) r.hi = 8'h9F;
        end else if (b >= 8'hF0 && b <= 8'hF4 && MAX_BYTES >= 4) begin
            r.nstate = S_NEED3;
            r.acc    = {12'd0, b[2:0]};
            r.len    = 3'd4;
            // F0 would be overlong below 90; F4 would exceed U+10FFFF above 8F
            if (b == 8'hF0) r.lo = 8'h90;
            if (b == 8'hF4) r.hi = 8'h8F;
        end else begin
            r.err = 1'b1;
        end
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic [7:0]               lo_q, lo_d;
    logic [7:0]               hi_q, hi_d;
    logic [14:0]              acc_q, acc_d;
    logic [2:0]               len_q, len_d;
    logic [7:0]               replay_q, replay_d;
    logic                     replay_pend_q, replay_pend_d;
    logic [20:0]              out_code_q;
    logic [2:0]               out_len_q;
    logic                     out_error_q;
    logic                     out_valid_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    logic                     slot_free;
    logic                     accept;
    logic                     do_replay;
    logic [7:0]               lead_byte;
    lead_t                    lead;
    logic                     cont_ok;
    logic                     use_lead;
    logic                     load;
    logic [20:0]              ld_code;
    logic [2:0]               ld_len;
    logic                     ld_err;
    logic [1:0]               err_inc;
    logic [ERR_CNT_WIDTH:0]   err_sum;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = slot_free && !replay_pend_q;
    assign accept    = in_valid && in_ready;
    // A pending replay byte is processed as soon as the output slot frees up
    assign do_replay = replay_pend_q && slot_free;
    assign lead_byte = replay_pend_q ? replay_q : in_byte;
    assign lead      = lead_decode(lead_byte);
    assign cont_ok   = (in_byte >= lo_q) && (in_byte <= hi_q);

    always_comb begin
        state_d       = state_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        acc_d         = acc_q;
        len_d         = len_q;
        replay_d      = replay_q;
        replay_pend_d = replay_pend_q;
        use_lead      = 1'b0;
        load          = 1'b0;
        ld_code       = 21'd0;
        ld_len        = 3'd0;
        ld_err        = 1'b0;
        err_inc       = 2'd0;

        if (do_replay) begin
            replay_pend_d = 1'b0;
            use_lead      = 1'b1;
        end else if (accept) begin
            if (state_q == S_IDLE) begin
                use_lead = 1'b1;
            end else if (cont_ok) begin
                acc_d = {acc_q[8:0], in_byte[5:0]};
                lo_d  = 8'h80;
                hi_d  = 8'hBF;
                case (state_q)
                    S_NEED3: state_d = S_NEED2;
                    S_NEED2: state_d = S_NEED1;
                    default: begin
                        state_d = S_IDLE;
                        load    = 1'b1;
                        ld_code = {acc_q, in_byte[5:0]};
                        ld_len  = len_q;
                    end
                endcase
            end else begin
                // Truncated sequence: the offending byte starts over as a lead
                err_inc = 2'd1;
                state_d = S_IDLE;
                lo_d    = 8'h80;
                hi_d    = 8'hBF;
                if (EMIT_REPLACEMENT) begin
                    load          = 1'b1;
                    ld_code       = REPLACEMENT;
                    ld_err        = 1'b1;
                    replay_d      = in_byte;
                    replay_pend_d = 1'b1;
                end else begin
                    use_lead = 1'b1;
                end
            end
        end

        if (use_lead) begin
            state_d = lead.nstate;
            lo_d    = lead.lo;
            hi_d    = lead.hi;
            acc_d   = lead.acc;
            len_d   = lead.len;
            if (lead.emit) begin
                load    = 1'b1;
                ld_code = {6'd0, lead.acc};
                ld_len  = lead.len;
            end
            if (lead.err) begin
                err_inc = err_inc + 2'd1;
                if (EMIT_REPLACEMENT) begin
                    load    = 1'b1;
                    ld_code = REPLACEMENT;
                    ld_len  = 3'd0;
                    ld_err  = 1'b1;
                end
            end
        end
    end

    // One extra bit catches overflow so the counter can saturate
    assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_WIDTH+1)'(err_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lo_q          <= 8'h80;
            hi_q          <= 8'hBF;
            acc_q         <= 15'd0;
            len_q         <= 3'd0;
            replay_q      <= 8'd0;
            replay_pend_q <= 1'b0;
            out_code_q    <= 21'd0;
            out_len_q     <= 3'd0;
            out_error_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            acc_q         <= acc_d;
            len_q         <= len_d;
            replay_q      <= replay_d;
            replay_pend_q <= replay_pend_d;
            if (load) begin
                out_valid_q <= 1'b1;
                out_code_q  <= ld_code;
                out_len_q   <= ld_len;
                out_error_q <= ld_err;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (err_sum[ERR_CNT_WIDTH]) begin
                err_cnt_q <= '1;
            end else begin
                err_cnt_q <= err_sum[ERR_CNT_WIDTH-1:0];
            end
        end
    end

    assign out_code  = out_code_q;
    assign out_len   = out_len_q;
    assign out_error = out_error_q;
    assign out_valid = out_valid_q;
    assign err_count = err_cnt_q;

endmodule
`default_nettype wire
